// File: rtl/key_event_decoder_if.sv
// Key event bus: the debounced key level in, one-cycle event strobes and
// status out. There is no handshake here. key_in is a plain level sampled on
// every rising clk edge. Each strobe is high for exactly one cycle and is not
// acknowledged.
interface key_event_decoder_if;
    logic       key_in;
    logic       short_pulse;
    logic       double_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       busy;
    logic [2:0] state_dbg;

    // Producer of key_in and consumer of the event strobes
    modport master (
        output key_in,
        input  short_pulse, double_pulse, long_pulse, repeat_pulse, busy, state_dbg
    );

    // The decoder itself
    modport slave (
        input  key_in,
        output short_pulse, double_pulse, long_pulse, repeat_pulse, busy, state_dbg
    );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced key level into one-cycle short, double,
// long and auto-repeat strobes. All timing is counted in clk cycles.
module key_event_decoder #(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DCLK_CYC   = 12_500_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    key_event_decoder_if.slave  bus
);
    localparam int MAX_AB  = (LONG_CYC > DCLK_CYC) ? LONG_CYC : DCLK_CYC;
    localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] DCLK_LAST   = CW'(DCLK_CYC - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          short_q, short_d;
    logic          double_q, double_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          busy_q, busy_d;

    // State, counter and arming flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Next state: each counter compare against N-1 fires on the N-th sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!bus.key_in) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = PRESS1;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (!bus.key_in) begin
                    state_d = WAIT2;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT2: begin
                if (bus.key_in) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == DCLK_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS2: begin
                cnt_d = '0;
                if (!bus.key_in) begin
                    state_d = IDLE;
                end
            end
            LONG_HOLD: begin
                if (!bus.key_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: the next-cycle strobes. The branches are exclusive, so at most one fires
    always_comb begin
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_q)
            PRESS1:    long_d   = bus.key_in && (cnt_q == LONG_LAST);
            WAIT2:     short_d  = !bus.key_in && (cnt_q == DCLK_LAST);
            PRESS2:    double_d = !bus.key_in;
            LONG_HOLD: repeat_d = bus.key_in && (cnt_q == REPEAT_LAST);
            default:   ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.short_pulse  = short_q;
    assign bus.double_pulse = double_q;
    assign bus.long_pulse   = long_q;
    assign bus.repeat_pulse = repeat_q;
    assign bus.busy         = busy_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Classifies a debounced, active-high key level into single-cycle event pulses: short press, double click, long press, and auto-repeat while held. Sits directly downstream of the key debounce stage and feeds application logic (counters, LED/mode control) with clean, one-cycle-wide event strobes. All timing is expressed in `clk` cycles, so the same block serves any clock rate via parameters.

## Interface
- `LONG_CYC`, default 50_000_000: consecutive high samples that qualify a long press; ≥2.
- `DCLK_CYC`, default 12_500_000: consecutive low samples after a first release that close the double-click window; ≥2.
- `REPEAT_CYC`, default 5_000_000: cycles between auto-repeat pulses while held after a long press; ≥2.
- Internal counter width `CW` = `$clog2` of the largest of the three parameters; must not overflow.
- Clock `clk`; reset `rst_n`, asynchronous, active-low.
- `clk  in  1` – system clock, rising edge.
- `rst_n  in  1` – asynchronous active-low reset.
- `key_in  in  1` – debounced key level, 1 = pressed; synchronous to `clk`.
- `short_pulse  out  1` – one-cycle strobe, single short press completed.
- `double_pulse  out  1` – one-cycle strobe, double click completed.
- `long_pulse  out  1` – one-cycle strobe, long-press threshold reached.
- `repeat_pulse  out  1` – one-cycle strobe, auto-repeat tick while held.
- `busy  out  1` – high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD. `cnt` is a CW-bit counter. `armed` is a 1-bit flag.
- All outputs are registered. Reset values: all pulses 0, `busy` 0, state IDLE, `cnt` 0, `armed` 0.
- **IDLE**
  - `key_in`=0: set `armed`.
  - `key_in`=1 and `armed`: go to PRESS1 with `cnt`=1.
  - `key_in`=1 and not `armed`: ignored. A key still held when reset is released produces no event until it has been seen low.
- **PRESS1**
  - `key_in`=1 and `cnt`==LONG_CYC-1: `long_pulse`, go to LONG_HOLD, `cnt`=0.
  - Otherwise `key_in`=1: `cnt`++.
  - `key_in`=0: go to WAIT2 with `cnt`=1.
- **WAIT2**
  - `key_in`=1: go to PRESS2, counter unused.
  - `key_in`=0 and `cnt`==DCLK_CYC-1: `short_pulse`, go to IDLE, `cnt`=0.
  - Otherwise `key_in`=0: `cnt`++.
- **PRESS2**
  - `key_in`=0: `double_pulse`, go to IDLE.
  - Holding here indefinitely produces no long or repeat event.
- **LONG_HOLD**
  - `key_in`=0: go to IDLE, no pulse.
  - `key_in`=1 and `cnt`==REPEAT_CYC-1: `repeat_pulse`, `cnt`=0.
  - Otherwise `key_in`=1: `cnt`++.
- At most one pulse output is high in any cycle. `busy` is the registered decode (state != IDLE).
- A reset asserted mid-operation returns everything to reset values immediately. Any pending event is discarded and never emitted.

## Timing
- Latency: each pulse is high for exactly the one cycle following the clock edge that sampled the qualifying `key_in` value.
- `long_pulse`: follows the LONG_CYC-th consecutive high sample.
- `short_pulse`: follows the DCLK_CYC-th consecutive low sample after the first release.
- Double-click window boundary: a re-press at low sample DCLK_CYC-1 still counts as double. A re-press at low sample DCLK_CYC or later gives `short_pulse`, then a new press in IDLE.
- A press of exactly LONG_CYC-1 high samples is short; exactly LONG_CYC is long.
- `repeat_pulse` first fires REPEAT_CYC cycles after `long_pulse`, then every REPEAT_CYC cycles.
- `busy` rises one cycle after the first accepted high sample. It falls in the same cycle that a terminal pulse is high, or one cycle after release from PRESS2 or LONG_HOLD.

## Test plan
Use LONG_CYC=8, DCLK_CYC=4, REPEAT_CYC=3 for all scenarios.
- Short: after reset, `key_in` low for 2 cycles, high 3, then low → `short_pulse` one cycle after the 4th low sample; no other pulse; `busy` 0 afterward.
- Double: high 3, low 2, high 2, low → `double_pulse` one cycle after the first low sample of the second release; no `short_pulse`.
- Long/repeat: high 20 samples, then low → `long_pulse` after sample 8; `repeat_pulse` after samples 11, 14, 17, 20; release gives no pulse; `busy` drops next cycle.
- Thresholds:
  - High 7 then low → no `long_pulse`; `short_pulse` 4 low samples later.
  - Gap of exactly 3 low samples then re-press → double.
  - Gap of 4 → `short_pulse`, then a fresh PRESS1.
- Reset/arming:
  - Assert `rst_n` during LONG_HOLD → all outputs 0 immediately.
  - Release reset with `key_in` held 10 cycles → no pulses.
  - Then low 1, high 3, low → normal `short_pulse`.
- One-hot check: random `key_in` for 10k cycles → never more than one pulse per cycle, every pulse exactly 1 cycle wide.
